// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a single-clock FIFO buffer: it arbitrates
// write/read requests and reports occupancy, thresholds, read-valid and sticky errors.
module fifo_ctrl #(
    parameter int DEPTH    = 7,
    parameter int AF_LEVEL = (1 << DEPTH) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             insert,
    output logic             remove,
    output logic [DEPTH:0]   wr_ptr,
    output logic [DEPTH:0]   rd_ptr,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             data_valid,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [DEPTH:0] AF_THR = (DEPTH + 1)'(AF_LEVEL);
    localparam logic [DEPTH:0] AE_THR = (DEPTH + 1)'(AE_LEVEL);

    logic [DEPTH:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH:0] rd_ptr_q, rd_ptr_d;
    logic           data_valid_q, data_valid_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    // Flags come only from registered pointers, so a request never feeds the
    // opposite strobe combinationally.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (wr_ptr_q[DEPTH] != rd_ptr_q[DEPTH]) &&
                          (wr_ptr_q[DEPTH-1:0] == rd_ptr_q[DEPTH-1:0]);
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    assign insert = wr_req & ~full  & ~flush & ~reset;
    assign remove = rd_req & ~empty & ~flush & ~reset;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_valid_d = remove;
        overflow_d   = overflow_q  | (wr_req & full);
        underflow_d  = underflow_q | (rd_req & empty);
        if (insert) wr_ptr_d = wr_ptr_q + 1'b1;
        if (remove) rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            data_valid_d = 1'b0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign wr_ptr     = wr_ptr_q;
    assign rd_ptr     = rd_ptr_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (DEPTH=3): occupancy reference model plus a
// behavioural buffer whose read data is scoreboarded against written words.
module tb_fifo_ctrl;

    localparam int DEPTH = 3;
    localparam int CAP   = 1 << DEPTH;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int PMOD  = 2 * CAP;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic flush  = 1'b0;
    logic wr_req = 1'b0;
    logic rd_req = 1'b0;
    logic insert, remove, full, empty, almost_full, almost_empty;
    logic data_valid, overflow, underflow;
    logic [DEPTH:0] wr_ptr, rd_ptr, count;

    fifo_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk_in(clk_in), .reset(reset), .flush(flush),
        .wr_req(wr_req), .rd_req(rd_req),
        .insert(insert), .remove(remove),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .data_valid(data_valid), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural storage buffer driven by the controller's pointers and strobes.
    logic [7:0] mem [CAP];
    logic [7:0] wdata = '0;
    logic [7:0] dout;
    always @(posedge clk_in) begin
        if (insert) mem[wr_ptr[DEPTH-1:0]] <= wdata;
        if (remove) dout <= mem[rd_ptr[DEPTH-1:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: totals of accepted writes/reads, stored words, sticky errors.
    int         wr_tot, rd_tot;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         m_ovf, m_udf, m_dv;

    function automatic int occ();
        return wr_tot - rd_tot;
    endfunction

    task automatic model_clear();
        wr_tot = 0; rd_tot = 0;
        m_ovf = 0; m_udf = 0; m_dv = 0;
        model_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},   32'(count),  32'(occ()));
        check({tag, ".wr_ptr"},  32'(wr_ptr), 32'(wr_tot % PMOD));
        check({tag, ".rd_ptr"},  32'(rd_ptr), 32'(rd_tot % PMOD));
        check({tag, ".full"},    32'(full),   32'(occ() == CAP));
        check({tag, ".empty"},   32'(empty),  32'(occ() == 0));
        check({tag, ".afull"},   32'(almost_full),  32'(occ() >= AF));
        check({tag, ".aempty"},  32'(almost_empty), 32'(occ() <= AE));
        check({tag, ".dvalid"},  32'(data_valid),   32'(m_dv));
        check({tag, ".ovf"},     32'(overflow),     32'(m_ovf));
        check({tag, ".udf"},     32'(underflow),    32'(m_udf));
    endtask

    // One cycle: check registered state, drive requests, check strobes, advance model.
    task automatic step(input string tag, input bit w, input bit r, input bit f);
        bit exp_ins, exp_rem;
        @(negedge clk_in);
        check_state(tag);
        wr_req = w; rd_req = r; flush = f;
        wdata  = 8'($urandom);
        #1;
        exp_ins = w && (occ() < CAP) && !f;
        exp_rem = r && (occ() > 0) && !f;
        check({tag, ".insert"}, 32'(insert), 32'(exp_ins));
        check({tag, ".remove"}, 32'(remove), 32'(exp_rem));
        @(posedge clk_in);
        if (f) begin
            model_clear();
        end else begin
            if (w && occ() == CAP) m_ovf = 1;
            if (r && occ() == 0)   m_udf = 1;
            if (exp_ins) begin wr_tot++; model_q.push_back(wdata); end
            if (exp_rem) begin rd_tot++; exp_q.push_back(model_q.pop_front()); end
            m_dv = exp_rem;
        end
    endtask

    // Monitor: every data_valid must present the oldest outstanding word.
    always @(negedge clk_in) begin
        if (!reset && data_valid === 1'b1) begin
            if (exp_q.size() == 0) check("dv_unexpected", 32'(1), 32'(0));
            else                   check("rd_data", 32'(dout), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #2;
        check_state("por");
        @(negedge clk_in);
        reset = 0;
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0);

        // Asynchronous reset mid-operation, between clock edges.
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0);
        step("pre_rst_rd", 0, 1, 0);
        @(negedge clk_in);
        wr_req = 0; rd_req = 0;
        #2 reset = 1;
        #1;
        model_clear();
        exp_q.delete();
        check_state("async_rst");
        @(negedge clk_in);
        reset = 0;
        for (int i = 0; i < 5; i++) step("idle2", 0, 0, 0);

        for (int i = 0; i < CAP; i++) step("fill", 1, 0, 0);
        step("over", 1, 0, 0);
        step("full_both", 1, 1, 0);
        step("refill", 1, 0, 0);
        for (int i = 0; i < CAP; i++) step("drain", 0, 1, 0);
        step("under", 0, 1, 0);
        step("empty_both", 1, 1, 0);
        step("to_empty", 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step("wrap_w", 1, 0, 0);
            step("wrap_r", 0, 1, 0);
        end
        for (int i = 0; i < 4; i++) step("to4", 1, 0, 0);
        for (int i = 0; i < 3; i++) step("mid_both", 1, 1, 0);
        step("to5", 1, 0, 0);
        step("flush", 1, 1, 1);
        step("post_flush", 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int wb;
            wb = (i < 200) ? 70 : 30;
            step("rand", $urandom_range(0, 99) < wb, $urandom_range(0, 99) < (100 - wb),
                 $urandom_range(0, 49) == 0);
        end
        step("tail", 0, 0, 0);
        step("tail", 0, 0, 0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
